// File: rtl/pll_startup_seq.sv
// Start-up and lock-supervision sequencer for the SPLL clock domain: holds the PLL
// domain in reset while it settles, then watches a synchronized heartbeat as a watchdog.
module pll_startup_seq #(
   parameter int SETTLE_CYCLES = 1024,
   parameter int HB_WINDOW     = 256,
   parameter int HB_MIN        = 4,
   parameter int MAX_RETRY     = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           hb_in,
   output logic                           dom_rst,
   output logic                           ready,
   output logic                           fault,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
   output logic [2:0]                     state
);

   localparam int RW   = $clog2(MAX_RETRY + 1);
   localparam int TMAX = (SETTLE_CYCLES > HB_WINDOW) ? SETTLE_CYCLES : HB_WINDOW;
   localparam int TW   = $clog2(TMAX);
   localparam int EW   = $clog2(HB_MIN + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [2:0]      hb_sync_q, hb_sync_d;
   logic            dom_rst_q, dom_rst_d;
   logic            ready_q, ready_d;
   logic            fault_q, fault_d;

   logic            hb_edge;
   logic [EW-1:0]   edge_total;
   logic            edges_ok;
   logic            settle_done;
   logic            window_done;

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the synchronizer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         edge_cnt_q <= '0;
         retry_q    <= '0;
         hb_sync_q  <= '0;
         dom_rst_q  <= 1'b1;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         edge_cnt_q <= edge_cnt_d;
         retry_q    <= retry_d;
         hb_sync_q  <= hb_sync_d;
         dom_rst_q  <= dom_rst_d;
         ready_q    <= ready_d;
         fault_q    <= fault_d;
      end
   end

   // Bits [1:0] form the synchronizer, bit 2 is the history sample for edge detection.
   always_comb begin
      hb_sync_d   = {hb_sync_q[1:0], hb_in};
      hb_edge     = hb_sync_q[1] ^ hb_sync_q[2];
      edge_total  = (edge_cnt_q == EW'(HB_MIN)) ? edge_cnt_q : edge_cnt_q + EW'(hb_edge);
      edges_ok    = (edge_total == EW'(HB_MIN));
      settle_done = (timer_q == TW'(SETTLE_CYCLES - 1));
      window_done = (timer_q == TW'(HB_WINDOW - 1));
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + TW'(1);
      edge_cnt_d = edge_total;
      retry_d    = retry_q;

      unique case (state_q)
         ST_IDLE: begin
            timer_d    = '0;
            edge_cnt_d = '0;
            retry_d    = '0;
            if (start) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            edge_cnt_d = '0;
            if (settle_done) begin
               state_d = ST_CHECK;
               timer_d = '0;
            end
         end
         ST_CHECK, ST_RUN: begin
            // The last-cycle edge pulse is already folded into edge_total.
            if (window_done) begin
               timer_d    = '0;
               edge_cnt_d = '0;
               if (edges_ok) begin
                  state_d = ST_RUN;
                  retry_d = '0;
               end else if (retry_q < RW'(MAX_RETRY)) begin
                  state_d = ST_SETTLE;
                  retry_d = retry_q + RW'(1);
               end else begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_FAULT: begin
            timer_d    = '0;
            edge_cnt_d = '0;
         end
         default: begin
            state_d    = ST_IDLE;
            timer_d    = '0;
            edge_cnt_d = '0;
            retry_d    = '0;
         end
      endcase

      // Dropping start overrides any window decision taken in the same cycle.
      if (!start) begin
         state_d    = ST_IDLE;
         timer_d    = '0;
         edge_cnt_d = '0;
         retry_d    = '0;
      end

      dom_rst_d = !((state_d == ST_CHECK) || (state_d == ST_RUN));
      ready_d   = (state_d == ST_RUN);
      fault_d   = (state_d == ST_FAULT);
   end

   assign dom_rst   = dom_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign state     = state_q;

endmodule
